// File: rtl/cla_serial_add_if.sv
// Handshake and data bundle for cla_serial_add: operand port (valid/ready in)
// and result port (valid/ready out). The master modport is the environment side.
interface cla_serial_add_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/cla_serial_add.sv
// Byte-serial WIDTH-bit adder: one 8-bit carry-lookahead slice per cycle, IDLE/CALC/DONE.
// Optional subtraction is enabled by defining the macro CLA_SUB_EN.
module cla_serial_add #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  cla_serial_add_if.slave  bus
);

  localparam int NBYTES = WIDTH / 8;
  localparam int IDXW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic [IDXW-1:0]  r_idx;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;

  logic [WIDTH-1:0] w_b_eff;
  logic             w_first_carry;
  logic [7:0]       w_cla_a;
  logic [7:0]       w_cla_b;
  logic [7:0]       w_cla_sum;
  logic             w_cla_cout;
  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_accept;
  logic             w_last;

  // 8-bit carry-lookahead slice: returns {cout, sum}
  function automatic logic [8:0] cla8(input logic [7:0] x, input logic [7:0] y,
                                      input logic ci);
    logic [7:0] g;
    logic [7:0] p;
    logic [8:0] c;
    g    = x & y;
    p    = x ^ y;
    c[0] = ci;
    for (int i = 0; i < 8; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    return {c[8], p ^ c[7:0]};
  endfunction

`ifdef CLA_SUB_EN
  assign w_b_eff       = bus.sub ? ~bus.b : bus.b;
  assign w_first_carry = bus.sub ? 1'b1 : bus.cin;
`else
  logic w_unused_sub;
  assign w_unused_sub  = bus.sub;
  assign w_b_eff       = bus.b;
  assign w_first_carry = bus.cin;
`endif

  assign w_cla_a  = r_a[{r_idx, 3'b000} +: 8];
  assign w_cla_b  = r_b[{r_idx, 3'b000} +: 8];
  assign {w_cla_cout, w_cla_sum} = cla8(w_cla_a, w_cla_b, r_carry);

  assign w_accept = (r_state == IDLE) && bus.in_valid;
  assign w_last   = (r_idx == IDX_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.in_valid)  w_next = CALC;
      CALC:    if (w_last)        w_next = DONE;
      DONE:    if (bus.out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Outputs decode registered state only
  always_comb begin
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      IDLE:    w_in_ready  = 1'b1;
      DONE:    w_out_valid = 1'b1;
      default: ;
    endcase
  end

  // Operand capture: pure data, no reset needed
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a <= bus.a;
      r_b <= w_b_eff;
    end
  end

  // Byte-serial datapath: one slice per CALC cycle, carry chained through r_carry
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_carry <= w_first_carry;
      r_idx   <= '0;
    end else if (r_state == CALC) begin
      r_sum[{r_idx, 3'b000} +: 8] <= w_cla_sum;
      r_carry                      <= w_cla_cout;
      if (w_last) begin
        r_cout <= w_cla_cout;
        r_ovf  <= (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_cla_sum[7] != r_a[WIDTH-1]);
      end else begin
        r_idx  <= r_idx + 1'b1;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
  assign bus.ovf       = r_ovf;

endmodule

// File: tb/tb_cla_serial_add.sv
// Directed self-checking bench for cla_serial_add (WIDTH=32); expectations hand-computed.
module tb_cla_serial_add;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   lat;
  logic [31:0] held;

  cla_serial_add_if #(.WIDTH(32)) bif ();

  cla_serial_add #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic [31:0] a, input logic [31:0] b,
                        input logic ci, input logic sb);
    bif.a        = a;
    bif.b        = b;
    bif.cin      = ci;
    bif.sub      = sb;
    bif.in_valid = 1'b1;
    tick();
    bif.in_valid = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (bif.out_valid !== 1'b1 && cycles < 20) begin
      tick();
      cycles++;
    end
  endtask

  task automatic release_result(input string tag);
    bif.out_ready = 1'b1;
    tick();
    bif.out_ready = 1'b0;
    chk({tag, "_in_ready_back"}, 64'(bif.in_ready), 64'd1);
    chk({tag, "_out_valid_low"}, 64'(bif.out_valid), 64'd0);
  endtask

  initial begin
    bif.in_valid  = 1'b0;
    bif.out_ready = 1'b0;
    bif.a         = '0;
    bif.b         = '0;
    bif.cin       = 1'b0;
    bif.sub       = 1'b0;
    rst_n         = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    chk("rst_in_ready",  64'(bif.in_ready),  64'd1);
    chk("rst_out_valid", 64'(bif.out_valid), 64'd0);
    chk("rst_sum",       64'(bif.sum),       64'd0);
    chk("rst_cout",      64'(bif.cout),      64'd0);
    chk("rst_ovf",       64'(bif.ovf),       64'd0);

    // Byte-carry propagation
    accept(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
    chk("add1_in_ready_busy", 64'(bif.in_ready), 64'd0);
    wait_done(lat);
    chk("add1_latency", 64'(lat),      64'd4);
    chk("add1_sum",     64'(bif.sum),  64'h0000_0100);
    chk("add1_cout",    64'(bif.cout), 64'd0);
    chk("add1_ovf",     64'(bif.ovf),  64'd0);
    release_result("add1");

    // Full ripple through every byte
    accept(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
    wait_done(lat);
    chk("ripple_latency", 64'(lat),      64'd4);
    chk("ripple_sum",     64'(bif.sum),  64'h0000_0000);
    chk("ripple_cout",    64'(bif.cout), 64'd1);
    chk("ripple_ovf",     64'(bif.ovf),  64'd0);
    release_result("ripple");

    // Signed overflow, then hold the result under backpressure
    accept(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    wait_done(lat);
    chk("ovf_latency", 64'(lat),      64'd4);
    chk("ovf_sum",     64'(bif.sum),  64'h8000_0000);
    chk("ovf_cout",    64'(bif.cout), 64'd0);
    chk("ovf_ovf",     64'(bif.ovf),  64'd1);
    held         = 32'h8000_0000;
    bif.in_valid = 1'b1;
    bif.a        = 32'h1111_1111;
    bif.b        = 32'h2222_2222;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_sum",       64'(bif.sum),       64'(held));
      chk("stall_in_ready",  64'(bif.in_ready),  64'd0);
      chk("stall_out_valid", 64'(bif.out_valid), 64'd1);
    end
    bif.in_valid = 1'b0;
    release_result("stall");

    // Second in_valid pulse during CALC must not be taken
    accept(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0);
    bif.a        = 32'h0000_0100;
    bif.b        = 32'h0000_0100;
    bif.cin      = 1'b1;
    bif.in_valid = 1'b1;
    tick();
    tick();
    bif.in_valid = 1'b0;
    chk("calc_pulse_in_ready", 64'(bif.in_ready), 64'd0);
    wait_done(lat);
    chk("calc_pulse_latency", 64'(lat + 2), 64'd4);
    chk("calc_pulse_sum",     64'(bif.sum), 64'h0000_0003);
    release_result("calc_pulse");
    tick();
    chk("calc_pulse_still_idle", 64'(bif.in_ready), 64'd1);

    // Reset at the second CALC cycle discards the partial result
    accept(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_in_ready",  64'(bif.in_ready),  64'd1);
    chk("midrst_out_valid", 64'(bif.out_valid), 64'd0);
    chk("midrst_sum",       64'(bif.sum),       64'd0);
    chk("midrst_cout",      64'(bif.cout),      64'd0);
    accept(32'h0F0F_0F0F, 32'h0101_0101, 1'b1, 1'b0);
    wait_done(lat);
    chk("post_rst_latency", 64'(lat),      64'd4);
    chk("post_rst_sum",     64'(bif.sum),  64'h1010_1011);
    chk("post_rst_cout",    64'(bif.cout), 64'd0);
    release_result("post_rst");

    // Subtract request: honoured only when the feature is built in
    accept(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1);
    wait_done(lat);
    chk("sub_latency", 64'(lat), 64'd4);
`ifdef CLA_SUB_EN
    chk("sub_sum",  64'(bif.sum),  64'hFFFF_FFFE);
`else
    chk("sub_sum",  64'(bif.sum),  64'h0000_000C);
`endif
    chk("sub_cout", 64'(bif.cout), 64'd0);
    chk("sub_ovf",  64'(bif.ovf),  64'd0);
    release_result("sub");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cla_serial_add.md
# cla_serial_add

Multi-cycle wide adder that accepts WIDTH-bit operand pairs over a valid/ready handshake and computes the sum byte-serially through one instance of the team's 8-bit carry-lookahead adder (CLA_8bit). It registers the inter-byte carry and assembles the result one byte per cycle. It presents the full-width sum, carry-out and signed-overflow flag on a valid/ready output port. The block sits directly upstream of CLA_8bit: it feeds it byte slices and carry-in, and consumes its sum and cout.

## Interface
- WIDTH, 32, operand/result width; must be a multiple of 8 and ≥ 16; NBYTES = WIDTH/8
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  operand pair offered
- in_ready  out  1  block can accept operands
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in for byte 0 (addition only)
- sub  in  1  subtract request; honoured only with CLA_SUB_EN
- out_valid  out  1  result held and valid
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  result
- cout  out  1  carry out of MSB byte
- ovf  out  1  two's-complement overflow

## Operation
- State machine: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch a into a_r and b_eff into b_r; set carry_r = first carry; idx=0; go to CALC.
- CALC:
  - CLA_8bit inputs: a_r[idx*8+:8], b_r[idx*8+:8], carry_r.
  - Each cycle: write the CLA sum into sum[idx*8+:8], load carry_r with the CLA cout, idx++.
  - When idx==NBYTES-1: also update cout and ovf, then go to DONE.
- DONE:
  - out_valid=1; sum, cout and ovf are stable.
  - On out_ready: go to IDLE.
- Addition: b_eff=b; first carry=cin.
- Subtraction (macro on, sub=1): b_eff=~b; first carry=1; cin ignored; cout=1 means no borrow.
- ovf = (a_r[MSB]==b_r[MSB]) && (sum[MSB]!=a_r[MSB]), using the already-inverted b_r.
- Arithmetic is modulo 2^WIDTH.
- sum bytes not yet written in CALC hold stale data, but out_valid=0 so they are not observable as a result.
- Boundary and corner cases:
  - in_valid while not in IDLE: ignored; a, b, cin and sub are not sampled.
  - out_ready while not in DONE: ignored.
  - out_valid held with out_ready low: stall indefinitely; outputs frozen.
  - rst_n low on any edge, including mid-CALC: next state IDLE; the partial result is discarded.
  - idx saturates logic: no wrap past NBYTES-1.

## Timing
- Reset values:
  - in_ready=1 after reset (IDLE).
  - out_valid=0, sum=0, cout=0, ovf=0.
  - carry_r=0, idx=0.
- Accept on edge T (in_valid & in_ready).
- CALC occupies edges T+1 … T+NBYTES.
- out_valid=1 from the cycle after edge T+NBYTES: 4 cycles latency at WIDTH=32.
- If out_ready=1 during the first DONE cycle, state is IDLE after edge T+NBYTES+1.
- in_ready reasserts in the following cycle; no input/output overlap.
- Peak throughput: one operation per NBYTES+2 cycles.
- in_ready and out_valid are decoded from registered state only. There is no combinational path from in_valid or out_ready.

## Configuration
- CLA_SUB_EN defined:
  - sub is sampled on accept and selects subtraction as above.
- CLA_SUB_EN undefined:
  - The sub port remains present but is ignored; the block always adds with cin.
  - The b inversion and the forced carry logic are not synthesised.

## Test plan
- Reset, then add: a=0x0000_00FF, b=0x0000_0001, cin=0 → after 4 cycles, out_valid=1, sum=0x0000_0100, cout=0, ovf=0. This checks byte-carry propagation.
- Full ripple: a=0xFFFF_FFFF, b=0x0000_0000, cin=1 → sum=0x0000_0000, cout=1, ovf=0.
- Signed overflow: a=0x7FFF_FFFF, b=0x0000_0001, cin=0 → sum=0x8000_0000, cout=0, ovf=1.
- Backpressure and handshake:
  - Hold out_ready=0 for 5 cycles after out_valid → sum stays constant and in_ready stays 0.
  - A second in_valid pulse during CALC is not accepted.
  - Release out_ready → in_ready=1 in the following cycle.
- Reset mid-operation: assert rst_n=0 at the second CALC cycle → next cycle in IDLE, in_ready=1, out_valid=0, sum=0. A new operation then completes normally.
- With CLA_SUB_EN: sub=1, a=0x0000_0005, b=0x0000_0007 → sum=0xFFFF_FFFE, cout=0, ovf=0.
- Without CLA_SUB_EN: same stimulus → sum=0x0000_000C.
